// File: rtl/voxel_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : voxel_mem_arbiter
//  Brief    : Two-requester Avalon-MM arbiter for the GPU master port.
//             Round-robin grant, grant lock across m1_waitrequest, and
//             in-order routing of pipelined read data through a tag FIFO.
//             Optional macro VOXEL_ARB_FIXED_PRIORITY_EN makes requester 0
//             always preferred instead of round-robin.
//  Revision : 1.0 - initial release
// ============================================================================
module voxel_mem_arbiter #(
  parameter int MAX_PENDING = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  // requester 0 : pixel writer
  input  logic [31:0] r0_address,
  input  logic        r0_read,
  input  logic        r0_write,
  input  logic [31:0] r0_writedata,
  output logic        r0_waitrequest,
  output logic [31:0] r0_readdata,
  output logic        r0_readdatavalid,
  // requester 1 : voxel fetch reader
  input  logic [31:0] r1_address,
  input  logic        r1_read,
  input  logic        r1_write,
  input  logic [31:0] r1_writedata,
  output logic        r1_waitrequest,
  output logic [31:0] r1_readdata,
  output logic        r1_readdatavalid,
  // Avalon-MM master
  output logic [31:0] m1_address,
  output logic [31:0] m1_writedata,
  output logic        m1_read,
  output logic        m1_write,
  input  logic        m1_waitrequest,
  input  logic [31:0] m1_readdata,
  input  logic        m1_readdatavalid
);

  localparam int c_AW = $clog2(MAX_PENDING);
  localparam int c_PW = c_AW + 1;
  localparam logic [c_PW-1:0] c_MAX = c_PW'(MAX_PENDING);

  typedef enum logic {
    S_UNLOCKED = 1'b0,
    S_LOCKED   = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_owner;
  logic             w_owner_nxt;
`ifndef VOXEL_ARB_FIXED_PRIORITY_EN
  logic             r_rr;
`endif
  logic [c_PW-1:0]        r_pending;
  logic [c_AW-1:0]        r_wptr;
  logic [c_AW-1:0]        r_rptr;
  logic [MAX_PENDING-1:0] r_tags;

  logic [1:0] w_rd;
  logic [1:0] w_wr;
  logic [1:0] w_req;
  logic [1:0] w_elig;
  logic       w_rd_ok;
  logic       w_pref;
  logic       w_present;
  logic       w_sel;
  logic       w_sel_rd;
  logic       w_sel_wr;
  logic       w_accept;
  logic       w_push;
  logic       w_pop;
  logic       w_head;

  assign w_rd    = {r1_read, r0_read};
  assign w_wr    = {r1_write, r0_write};
  assign w_req   = w_rd | w_wr;
  // Reads need a free tag slot as counted at the start of the cycle.
  assign w_rd_ok = (r_pending < c_MAX);
  assign w_elig  = (w_rd & {2{w_rd_ok}}) | (w_wr & ~w_rd);

`ifdef VOXEL_ARB_FIXED_PRIORITY_EN
  assign w_pref = 1'b0;
`else
  assign w_pref = r_rr;
`endif

  // Grant selection and lock next-state; the held owner bypasses arbitration.
  always_comb begin
    w_present   = 1'b0;
    w_sel       = 1'b0;
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      S_UNLOCKED: begin
        if (w_elig[w_pref]) begin
          w_present = 1'b1;
          w_sel     = w_pref;
        end else if (w_elig[~w_pref]) begin
          w_present = 1'b1;
          w_sel     = ~w_pref;
        end
      end
      S_LOCKED: begin
        w_present = w_req[r_owner];
        w_sel     = r_owner;
      end
      default: begin
        w_present = 1'b0;
        w_sel     = 1'b0;
      end
    endcase
    // Nothing is presented while reset is asserted.
    if (!reset_n) begin
      w_present = 1'b0;
    end
    if (w_present && m1_waitrequest) begin
      w_state_nxt = S_LOCKED;
      w_owner_nxt = w_sel;
    end else if (w_present) begin
      w_state_nxt = S_UNLOCKED;
    end
  end

  assign w_sel_rd = w_sel ? r1_read  : r0_read;
  assign w_sel_wr = w_sel ? r1_write : r0_write;
  assign w_accept = w_present & ~m1_waitrequest;
  assign w_push   = w_accept & w_sel_rd;
  // A response with nothing outstanding is a stray and is dropped.
  assign w_pop    = m1_readdatavalid & (r_pending != '0) & reset_n;
  assign w_head   = r_tags[r_rptr];

  assign m1_read      = w_present & w_sel_rd;
  assign m1_write     = w_present & ~w_sel_rd & w_sel_wr;
  assign m1_address   = w_present ? (w_sel ? r1_address : r0_address) : 32'h0;
  assign m1_writedata = (w_present & ~w_sel_rd) ? (w_sel ? r1_writedata : r0_writedata) : 32'h0;

  assign r0_waitrequest   = ~(w_accept & ~w_sel);
  assign r1_waitrequest   = ~(w_accept & w_sel);
  assign r0_readdata      = m1_readdata;
  assign r1_readdata      = m1_readdata;
  assign r0_readdatavalid = w_pop & ~w_head;
  assign r1_readdatavalid = w_pop & w_head;

  // Grant lock state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_UNLOCKED;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

`ifndef VOXEL_ARB_FIXED_PRIORITY_EN
  // Round-robin pointer moves to the other requester on every acceptance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr <= 1'b0;
    end else if (w_accept) begin
      r_rr <= ~w_sel;
    end
  end
`endif

  // Tag FIFO and outstanding-read counter; push and pop may coincide.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tags    <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_pending <= '0;
    end else begin
      if (w_push) begin
        r_tags[r_wptr] <= w_sel;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_pending <= r_pending + 1'b1;
        2'b01:   r_pending <= r_pending - 1'b1;
        default: r_pending <= r_pending;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_voxel_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_voxel_mem_arbiter
//  Brief    : Directed self-checking bench for voxel_mem_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_voxel_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] r0_address, r1_address, r0_writedata, r1_writedata;
  logic        r0_read, r0_write, r1_read, r1_write;
  logic        r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid;
  logic [31:0] r0_readdata, r1_readdata;
  logic [31:0] m1_address, m1_writedata, m1_readdata;
  logic        m1_read, m1_write, m1_waitrequest, m1_readdatavalid;

  int n_tests = 0;
  int n_fail  = 0;

  voxel_mem_arbiter #(.MAX_PENDING(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .r0_address(r0_address), .r0_read(r0_read), .r0_write(r0_write),
    .r0_writedata(r0_writedata), .r0_waitrequest(r0_waitrequest),
    .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
    .r1_address(r1_address), .r1_read(r1_read), .r1_write(r1_write),
    .r1_writedata(r1_writedata), .r1_waitrequest(r1_waitrequest),
    .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
    .m1_address(m1_address), .m1_writedata(m1_writedata),
    .m1_read(m1_read), .m1_write(m1_write), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    r0_address = 0; r0_read = 0; r0_write = 0; r0_writedata = 0;
    r1_address = 0; r1_read = 0; r1_write = 0; r1_writedata = 0;
    m1_waitrequest = 0; m1_readdatavalid = 0; m1_readdata = 0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    r0_write = 1; r0_address = 32'h1234; r1_read = 1; m1_readdatavalid = 1;
    #1;
    n_tests++; if (m1_write !== 1'b0) begin n_fail++; $display("FAIL reset_m1_write got %0h exp 0", m1_write); end
    n_tests++; if (m1_read !== 1'b0) begin n_fail++; $display("FAIL reset_m1_read got %0h exp 0", m1_read); end
    n_tests++; if (m1_address !== 32'h0) begin n_fail++; $display("FAIL reset_m1_address got %0h exp 0", m1_address); end
    n_tests++; if (r0_waitrequest !== 1'b1 || r1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL reset_waitrequest got %0b%0b exp 11", r1_waitrequest, r0_waitrequest); end
    n_tests++; if (r0_readdatavalid !== 1'b0 || r1_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL reset_rdv got %0b%0b exp 00", r1_readdatavalid, r0_readdatavalid); end
    step();
    reset_n = 1;
    idle();
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_addr;
    do_reset();
    r0_write = 1; r0_address = 32'h1000; r0_writedata = 32'hD0;
    r1_write = 1; r1_address = 32'h2000; r1_writedata = 32'hD1;
    for (int i = 0; i < 4; i++) begin
      #1;
`ifdef VOXEL_ARB_FIXED_PRIORITY_EN
      exp_addr = 32'h1000;
`else
      exp_addr = (i % 2 == 0) ? 32'h1000 : 32'h2000;
`endif
      n_tests++; if (m1_address !== exp_addr || m1_write !== 1'b1) begin n_fail++; $display("FAIL rr_addr[%0d] got %0h/w%0b exp %0h/w1", i, m1_address, m1_write, exp_addr); end
      n_tests++; if (m1_writedata !== ((exp_addr == 32'h1000) ? 32'hD0 : 32'hD1)) begin n_fail++; $display("FAIL rr_wdata[%0d] got %0h", i, m1_writedata); end
      step();
    end
    idle();
  endtask

  task automatic test_lock();
    do_reset();
    r1_read = 1; r1_address = 32'h100; m1_waitrequest = 1;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) begin r0_write = 1; r0_address = 32'h50; end
      if (c == 4) m1_waitrequest = 0;
      #1;
      n_tests++; if (m1_address !== 32'h100 || m1_read !== 1'b1) begin n_fail++; $display("FAIL lock_addr[%0d] got %0h/r%0b exp 100/r1", c, m1_address, m1_read); end
      n_tests++; if (r0_waitrequest !== 1'b1) begin n_fail++; $display("FAIL lock_r0_wait[%0d] got %0b exp 1", c, r0_waitrequest); end
      n_tests++; if (r1_waitrequest !== (c != 4)) begin n_fail++; $display("FAIL lock_r1_wait[%0d] got %0b exp %0b", c, r1_waitrequest, (c != 4)); end
      step();
    end
    r1_read = 0;
    #1;
    n_tests++; if (m1_address !== 32'h50 || m1_write !== 1'b1 || r0_waitrequest !== 1'b0) begin n_fail++; $display("FAIL lock_r0_grant got %0h/w%0b/wait%0b exp 50/w1/wait0", m1_address, m1_write, r0_waitrequest); end
    step();
    idle();
  endtask

  task automatic test_routing();
    do_reset();
    r0_read = 1; r0_address = 32'h10; r1_read = 1; r1_address = 32'h20;
    #1;
    n_tests++; if (m1_address !== 32'h10 || r0_waitrequest !== 1'b0 || r1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL route_first got %0h/%0b%0b exp 10/r1wait1 r0wait0", m1_address, r1_waitrequest, r0_waitrequest); end
    step();
    r0_read = 0;
    #1;
    n_tests++; if (m1_address !== 32'h20 || r1_waitrequest !== 1'b0) begin n_fail++; $display("FAIL route_second got %0h/%0b exp 20/0", m1_address, r1_waitrequest); end
    step();
    r1_read = 0; m1_readdatavalid = 1; m1_readdata = 32'hAAAA;
    #1;
    n_tests++; if (r0_readdatavalid !== 1'b1 || r1_readdatavalid !== 1'b0 || r0_readdata !== 32'hAAAA) begin n_fail++; $display("FAIL route_ret0 got rdv %0b%0b data %0h exp 01 AAAA", r1_readdatavalid, r0_readdatavalid, r0_readdata); end
    step();
    m1_readdata = 32'hBBBB;
    #1;
    n_tests++; if (r1_readdatavalid !== 1'b1 || r0_readdatavalid !== 1'b0 || r1_readdata !== 32'hBBBB) begin n_fail++; $display("FAIL route_ret1 got rdv %0b%0b data %0h exp 10 BBBB", r1_readdatavalid, r0_readdatavalid, r1_readdata); end
    step();
    idle();
  endtask

  task automatic test_max_pending();
    do_reset();
    r1_read = 1;
    for (int i = 0; i < 4; i++) begin
      r1_address = 32'h200 + i;
      #1;
      n_tests++; if (r1_waitrequest !== 1'b0) begin n_fail++; $display("FAIL maxp_fill[%0d] got wait %0b exp 0", i, r1_waitrequest); end
      step();
    end
    r1_address = 32'h204; r0_write = 1; r0_address = 32'h60;
    #1;
    n_tests++; if (m1_write !== 1'b1 || m1_address !== 32'h60 || r0_waitrequest !== 1'b0 || r1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL maxp_write_pass got %0h/w%0b/%0b%0b exp 60/w1/r1wait1 r0wait0", m1_address, m1_write, r1_waitrequest, r0_waitrequest); end
    step();
    r0_write = 0;
    #1;
    n_tests++; if (m1_read !== 1'b0 || r1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL maxp_stall got r%0b wait %0b exp r0 wait1", m1_read, r1_waitrequest); end
    step();
    m1_readdatavalid = 1; m1_readdata = 32'h1;
    #1;
    n_tests++; if (r1_readdatavalid !== 1'b1 || r1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL maxp_ret got rdv %0b wait %0b exp rdv1 wait1", r1_readdatavalid, r1_waitrequest); end
    step();
    m1_readdatavalid = 0;
    #1;
    n_tests++; if (r1_waitrequest !== 1'b0 || m1_read !== 1'b1 || m1_address !== 32'h204) begin n_fail++; $display("FAIL maxp_resume got wait %0b r%0b %0h exp wait0 r1 204", r1_waitrequest, m1_read, m1_address); end
    step();
    idle();
  endtask

  task automatic test_simultaneous();
    logic [3:0] ret_tags;
    logic       t;
    do_reset();
    // issue tags 0,1,0
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin r1_read = 1; r1_address = 32'h31; end
      else begin r0_read = 1; r0_address = 32'h30 + i; end
      #1;
      n_tests++; if ((i == 1 ? r1_waitrequest : r0_waitrequest) !== 1'b0) begin n_fail++; $display("FAIL simul_issue[%0d] got wait 1 exp 0", i); end
      step();
      r0_read = 0; r1_read = 0;
    end
    r1_read = 1; r1_address = 32'h33; m1_readdatavalid = 1; m1_readdata = 32'hC0;
    #1;
    n_tests++; if (r1_waitrequest !== 1'b0 || r0_readdatavalid !== 1'b1 || r1_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL simul_pushpop got wait %0b rdv %0b%0b exp wait0 rdv 01", r1_waitrequest, r1_readdatavalid, r0_readdatavalid); end
    step();
    r1_read = 0; m1_readdatavalid = 0;
    // outstanding tags now 1,0,1; one more read fits, the next must stall
    r0_read = 1; r0_address = 32'h34;
    #1;
    n_tests++; if (r0_waitrequest !== 1'b0) begin n_fail++; $display("FAIL simul_fourth got wait %0b exp 0", r0_waitrequest); end
    step();
    r0_read = 0; r1_read = 1; r1_address = 32'h35;
    #1;
    n_tests++; if (r1_waitrequest !== 1'b1 || m1_read !== 1'b0) begin n_fail++; $display("FAIL simul_full got wait %0b r%0b exp wait1 r0", r1_waitrequest, m1_read); end
    step();
    r1_read = 0;
    ret_tags = 4'b0101; // returns in order: 1,0,1,0 (bit i = tag of return i)
    for (int i = 0; i < 4; i++) begin
      m1_readdatavalid = 1; m1_readdata = 32'hD0 + i;
      t = ret_tags[i];
      #1;
      n_tests++; if (r1_readdatavalid !== t || r0_readdatavalid !== ~t || (t ? r1_readdata : r0_readdata) !== (32'hD0 + i)) begin n_fail++; $display("FAIL simul_ret[%0d] got rdv %0b%0b exp tag %0b", i, r1_readdatavalid, r0_readdatavalid, t); end
      step();
    end
    #1;
    n_tests++; if (r0_readdatavalid !== 1'b0 || r1_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL simul_stray got rdv %0b%0b exp 00", r1_readdatavalid, r0_readdatavalid); end
    step();
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    r0_read = 1; r0_address = 32'h40;
    #1; step();
    r0_read = 0; r1_read = 1; r1_address = 32'h41;
    #1; step();
    r1_read = 0; r0_write = 1; r0_address = 32'h70; m1_waitrequest = 1;
    #1;
    n_tests++; if (m1_write !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got w%0b exp w1", m1_write); end
    reset_n = 0;
    #1;
    n_tests++; if (m1_write !== 1'b0 || m1_address !== 32'h0 || r0_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rmid_drop got w%0b %0h wait %0b exp w0 0 wait1", m1_write, m1_address, r0_waitrequest); end
    step();
    reset_n = 1; r0_write = 0; m1_waitrequest = 0;
    for (int i = 0; i < 2; i++) begin
      m1_readdatavalid = 1; m1_readdata = 32'hE0 + i;
      #1;
      n_tests++; if (r0_readdatavalid !== 1'b0 || r1_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rmid_discard[%0d] got rdv %0b%0b exp 00", i, r1_readdatavalid, r0_readdatavalid); end
      step();
    end
    m1_readdatavalid = 0; r1_read = 1; r1_address = 32'h42;
    #1; step();
    r1_read = 0; m1_readdatavalid = 1; m1_readdata = 32'hF00D;
    #1;
    n_tests++; if (r1_readdatavalid !== 1'b1 || r0_readdatavalid !== 1'b0 || r1_readdata !== 32'hF00D) begin n_fail++; $display("FAIL rmid_after got rdv %0b%0b data %0h exp 10 F00D", r1_readdatavalid, r0_readdatavalid, r1_readdata); end
    step();
    idle();
  endtask

  initial begin
    reset_n = 0;
    idle();
    test_reset();
    test_round_robin();
    test_lock();
    test_routing();
    test_max_pending();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/voxel_mem_arbiter.md
# voxel_mem_arbiter

Shares the GPU's single Avalon-MM master port (toward SDRAM and the pixel buffers) between two internal requesters: requester 0 is the pixel writer, requester 1 is the voxel fetch reader. The block has three jobs: grant round-robin, hold each grant stable through `m1_waitrequest`, and return pipelined read data to the requester that issued the read, using an in-order tag FIFO. It sits between the GPU datapath and the `m1_*` master interface of `voxel_gpu`.

## Interface
Parameters:
- `MAX_PENDING`, default 4: maximum outstanding reads; also the tag FIFO depth. Power of 2, range 2..16.

Ports:
- `clock` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `rN_address` in 32 (N = 0, 1): requester word address.
- `rN_read` in 1: read request.
- `rN_write` in 1: write request.
- `rN_writedata` in 32: write data.
- `rN_waitrequest` out 1: command not accepted this cycle.
- `rN_readdata` out 32: routed read data.
- `rN_readdatavalid` out 1: read data valid for requester N.
- `m1_address` out 32, `m1_writedata` out 32, `m1_read` out 1, `m1_write` out 1: Avalon-MM master command.
- `m1_waitrequest` in 1, `m1_readdata` in 32, `m1_readdatavalid` in 1: Avalon-MM master response.

## Operation
- A requester is requesting when `rN_read | rN_write`. If it asserts both, the read wins and the write is ignored for that command.
- Grant state: `locked` (1 bit) and `owner` (1 bit). Round-robin pointer `rr` (1 bit) names the preferred requester.
- Unlocked cycle:
  - Winner = `rr` if it is requesting and eligible, else the other requester if it is requesting and eligible.
  - A read is eligible only when `pending < MAX_PENDING`. Writes are always eligible.
  - The winner's command drives `m1_*` combinationally in the same cycle.
- If `m1_waitrequest` = 1 while a command is presented, set `locked` = 1 and `owner` = winner. The command stays on `m1_*` from `owner`'s inputs until accepted; no re-arbitration while locked. Requesters must hold their command stable while their `rN_waitrequest` = 1.
- Acceptance = command presented and `m1_waitrequest` = 0. On acceptance:
  - clear `locked`;
  - set `rr` to the other requester;
  - for a read: push the owner ID into the tag FIFO and increment `pending`.
- `rN_waitrequest` = 1 unless requester N's command is accepted this cycle. It is also 1 when requester N is idle.
- No command presented: `m1_read` = `m1_write` = 0, `m1_address` = `m1_writedata` = 0.
- On `m1_readdatavalid`: pop the FIFO head, drive `m1_readdata` to both `rN_readdata`, and assert `rN_readdatavalid` only for N = head tag. Decrement `pending`.
- Read acceptance and readdatavalid in the same cycle: push and pop both happen, and `pending` is unchanged. This is legal even when `pending` = `MAX_PENDING`, but the read is only eligible if `pending < MAX_PENDING` at the start of the cycle.
- Readdatavalid with `pending` = 0 (stray or post-reset response): discard it. No `rN_readdatavalid`, no counter underflow.
- `pending` is `$clog2(MAX_PENDING)+1` bits wide. The FIFO read and write pointers wrap modulo `MAX_PENDING`.

## Timing
- Request-to-master latency is 0 cycles (combinational mux). Read-return routing is 0 cycles after `m1_readdatavalid`.
- Reset values: `locked` = 0, `owner` = 0, `rr` = 0, `pending` = 0, FIFO empty.
- Output values during reset: all `m1_*` outputs 0, `rNreaddatavalid` 0, `rN_waitrequest` 1.
- Reset asserted mid-transaction: the grant is dropped immediately (asynchronous). Outstanding read tags are lost; any responses arriving after reset fall under the `pending` = 0 discard rule.
- Back-to-back: when both requesters hold requests and `m1_waitrequest` = 0, grants alternate every cycle.

## Configuration
- `VOXEL_ARB_FIXED_PRIORITY_EN`
  - Defined: requester 0 always wins arbitration when it is requesting and eligible, and `rr` is unused.
  - Undefined: round-robin as described above.
  - Lock, tag FIFO and read-routing behaviour are identical in both cases.

## Test plan
- Both requesters issue continuous writes, `m1_waitrequest` = 0 -> `m1_address` alternates r0, r1, r0, r1 each cycle. With the macro defined, r0 only.
- r1 read to 0x100, `m1_waitrequest` held 1 for 3 cycles while r0 requests -> r1's address stays on `m1_address` for 4 cycles; `r0_waitrequest` = 1 throughout; r0 is granted on cycle 5.
- r0 reads 0x10, r1 reads 0x20, slave returns 0xAAAA then 0xBBBB -> `r0_readdatavalid` with 0xAAAA, then `r1_readdatavalid` with 0xBBBB.
- `MAX_PENDING` = 4, four reads accepted with no return -> 5th read stalls (`rN_waitrequest` = 1) while a concurrent write is still accepted. One return frees a slot and the next read issues.
- Read accepted in the same cycle as a readdatavalid at `pending` = 3 -> `pending` stays 3 and routing stays in order.
- `reset_n` pulsed low with 2 reads outstanding, then 2 readdatavalids arrive -> no `rN_readdatavalid`, `pending` stays 0.
